// File: rtl/rv_fetch_frontend.sv
// rv_fetch_frontend: halfword realignment buffer plus static branch predictor.
// 32-bit fetched words are split into halfword entries and re-assembled into
// aligned 16/32-bit instructions for decode.
// Optional feature macro: FETCH_BRANCH_PRED_EN (predictor + shadow ra).
module rv_fetch_frontend #(
    parameter int unsigned INSTR_BUF_ADDR_SIZE = 2,
    parameter int unsigned EXTENSION_C         = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_pc_select,
    input  logic        i_ack,
    input  logic [31:0] i_data,
    input  logic        i_fetch_pc1,
    input  logic [31:0] i_fetch_pc_prev,
    input  logic        i_ra_invalidate,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_reg_wdata,
    output logic        o_bp_need,
    output logic [31:0] o_bp_addr,
    output logic        o_free_dword_or_more,
    output logic [31:0] o_pc_incr,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_branch_pred,
    output logic        o_ready
);

    localparam int unsigned PTR_W = INSTR_BUF_ADDR_SIZE + 1;
    localparam int unsigned DEPTH = 1 << PTR_W;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Halfword entry storage
    logic [15:0]      buf_data_q [DEPTH];
    logic [30:0]      buf_pc_q   [DEPTH];
    logic             buf_bp_q   [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d, wptr_nx;
    logic [PTR_W-1:0] rptr_q, rptr_d, rptr_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             bp_prev_q;
    logic             drop_hi_c;

    logic             wr_en;
    logic             hi_only;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [1:0]       need_n;
    logic [15:0]      wr_data0;
    logic [30:0]      wr_pc0;
    logic [30:0]      wr_pc1;
    logic [15:0]      head0;
    logic [15:0]      head1;
    logic             head_is_c;
    logic [CNT_W-1:0] free_hw;

    logic unused_pc_bit0;
    assign unused_pc_bit0 = i_fetch_pc_prev[0];

`ifdef FETCH_BRANCH_PRED_EN
    logic [31:0] ra_q;
    logic        ra_valid_q;
    logic        pred_active;
    logic [15:0] pred_hw;
    logic        pred_is_c;
    logic [31:0] j_imm;
    logic [31:0] cj_imm;
    logic        is_jal;
    logic        is_ret;
    logic        is_cj;
    logic        is_cjr;

    // Decode the instruction starting at the fetched halfword for prediction
    always_comb begin
        pred_active = i_ack & ~bp_prev_q;
        pred_hw     = i_fetch_pc_prev[1] ? i_data[31:16] : i_data[15:0];
        pred_is_c   = (pred_hw[1:0] != 2'b11);
        j_imm       = {{11{i_data[31]}}, i_data[31], i_data[19:12], i_data[20],
                       i_data[30:21], 1'b0};
        cj_imm      = {{20{pred_hw[12]}}, pred_hw[12], pred_hw[8], pred_hw[10:9],
                       pred_hw[6], pred_hw[7], pred_hw[2], pred_hw[11],
                       pred_hw[5:3], 1'b0};
        // 32-bit forms are only recognised when they start at the low half
        is_jal      = ~i_fetch_pc_prev[1] & (i_data[6:0] == 7'b1101111);
        is_ret      = ~i_fetch_pc_prev[1] & (i_data[6:0] == 7'b1100111)
                    & (i_data[14:12] == 3'b000) & (i_data[19:15] == 5'd1)
                    & (i_data[31:20] == 12'd0);
        is_cj       = (EXTENSION_C != 0) & pred_is_c & (pred_hw[1:0] == 2'b01)
                    & ((pred_hw[15:13] == 3'b101) | (pred_hw[15:13] == 3'b001));
        is_cjr      = (EXTENSION_C != 0) & (pred_hw == 16'h8082);

        o_bp_need = 1'b0;
        o_bp_addr = 32'd0;
        if (pred_active) begin
            if (is_jal) begin
                o_bp_need = 1'b1;
                o_bp_addr = i_fetch_pc_prev + j_imm;
            end else if (is_ret && ra_valid_q) begin
                o_bp_need = 1'b1;
                o_bp_addr = ra_q;
            end else if (is_cj) begin
                o_bp_need = 1'b1;
                o_bp_addr = i_fetch_pc_prev + cj_imm;
            end else if (is_cjr && ra_valid_q) begin
                o_bp_need = 1'b1;
                o_bp_addr = ra_q;
            end
        end
        drop_hi_c = o_bp_need & pred_is_c;
    end

    // Remember a prediction so the following sequential word is discarded
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bp_prev_q <= 1'b0;
        end else begin
            bp_prev_q <= o_bp_need;
        end
    end

    // Shadow copy of x1 for return prediction; invalidate has priority
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ra_q       <= 32'd0;
            ra_valid_q <= 1'b0;
        end else begin
            if (i_reg_write && (i_rd == 5'd1)) begin
                ra_q       <= i_reg_wdata;
                ra_valid_q <= 1'b1;
            end
            if (i_ra_invalidate) begin
                ra_valid_q <= 1'b0;
            end
        end
    end
`else
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{i_ra_invalidate, i_reg_write, i_rd, i_reg_wdata};
    assign o_bp_need = 1'b0;
    assign o_bp_addr = 32'd0;
    assign bp_prev_q = 1'b0;
    assign drop_hi_c = 1'b0;
`endif

    // Push side: choose which halves of the acked word enter the buffer
    always_comb begin
        wr_en    = i_ack & ~i_flush & ~i_pc_select & ~bp_prev_q;
        hi_only  = i_fetch_pc_prev[1];
        wr_data0 = hi_only ? i_data[31:16] : i_data[15:0];
        wr_pc0   = i_fetch_pc_prev[31:1];
        wr_pc1   = i_fetch_pc_prev[31:1] + 31'd1;
        push_n   = 2'd0;
        if (wr_en) begin
            push_n = (hi_only || drop_hi_c) ? 2'd1 : 2'd2;
        end
    end

    // Pop side: assemble the head instruction and decide whether it leaves
    always_comb begin
        rptr_nx       = rptr_q + PTR_W'(1);
        head0         = buf_data_q[rptr_q];
        head1         = buf_data_q[rptr_nx];
        head_is_c     = (head0[1:0] != 2'b11);
        need_n        = head_is_c ? 2'd1 : 2'd2;
        o_ready       = (cnt_q >= CNT_W'(need_n)) & ~i_flush & ~i_pc_select;
        o_instruction = head_is_c ? {16'h0000, head0} : {head1, head0};
        o_pc          = {buf_pc_q[rptr_q], 1'b0};
        o_branch_pred = buf_bp_q[rptr_q];
        pop_n         = (o_ready && !i_stall) ? need_n : 2'd0;
    end

    // Pointer/count next state; a redirect empties the buffer
    always_comb begin
        wptr_nx = wptr_q + PTR_W'(1);
        wptr_d  = wptr_q + PTR_W'(push_n);
        rptr_d  = rptr_q + PTR_W'(pop_n);
        cnt_d   = cnt_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (i_flush || i_pc_select) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    // Room for the word in flight plus one new request
    always_comb begin
        free_hw              = CNT_W'(DEPTH) - cnt_q;
        o_free_dword_or_more = (free_hw >= CNT_W'(4));
        o_pc_incr            = i_fetch_pc1 ? 32'd2 : 32'd4;
    end

    // Pointer and count registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry writes; the jump's first halfword carries the prediction tag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= 16'd0;
                buf_pc_q[i]   <= 31'd0;
                buf_bp_q[i]   <= 1'b0;
            end
        end else begin
            if (push_n != 2'd0) begin
                buf_data_q[wptr_q] <= wr_data0;
                buf_pc_q[wptr_q]   <= wr_pc0;
                buf_bp_q[wptr_q]   <= o_bp_need;
            end
            if (push_n == 2'd2) begin
                buf_data_q[wptr_nx] <= i_data[31:16];
                buf_pc_q[wptr_nx]   <= wr_pc1;
                buf_bp_q[wptr_nx]   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_frontend.sv
// Scoreboard bench for rv_fetch_frontend: expected instructions are queued
// at stimulus time and compared by a monitor as decode consumes them.
module tb_rv_fetch_frontend;

`ifdef FETCH_BRANCH_PRED_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bp;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_pc_select = 1'b0;
    logic        i_ack = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic        i_fetch_pc1 = 1'b0;
    logic [31:0] i_fetch_pc_prev = 32'd0;
    logic        i_ra_invalidate = 1'b0;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_rd = 5'd0;
    logic [31:0] i_reg_wdata = 32'd0;
    logic        o_bp_need;
    logic [31:0] o_bp_addr;
    logic        o_free_dword_or_more;
    logic [31:0] o_pc_incr;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_branch_pred;
    logic        o_ready;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    rv_fetch_frontend #(.INSTR_BUF_ADDR_SIZE(2), .EXTENSION_C(1)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_stall(i_stall),
        .i_pc_select(i_pc_select), .i_ack(i_ack), .i_data(i_data),
        .i_fetch_pc1(i_fetch_pc1), .i_fetch_pc_prev(i_fetch_pc_prev),
        .i_ra_invalidate(i_ra_invalidate), .i_reg_write(i_reg_write), .i_rd(i_rd),
        .i_reg_wdata(i_reg_wdata), .o_bp_need(o_bp_need), .o_bp_addr(o_bp_addr),
        .o_free_dword_or_more(o_free_dword_or_more), .o_pc_incr(o_pc_incr),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_branch_pred(o_branch_pred),
        .o_ready(o_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc, input logic bp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.bp    = bp;
        sb.push_back(e);
    endtask

    // One acked word; prediction outputs are checked inside the ack cycle
    task automatic ack(input logic [31:0] d, input logic [31:0] pc,
                       input logic exp_need, input logic [31:0] exp_addr);
        i_ack           = 1'b1;
        i_data          = d;
        i_fetch_pc_prev = pc;
        #1;
        chk("bp_need", 32'(o_bp_need), 32'(exp_need));
        chk("bp_addr", o_bp_addr, exp_addr);
        @(posedge i_clk); #1;
        i_ack = 1'b0;
    endtask

    task automatic reg_wr(input logic [4:0] rd, input logic [31:0] d, input logic inv);
        i_reg_write     = 1'b1;
        i_rd            = rd;
        i_reg_wdata     = d;
        i_ra_invalidate = inv;
        @(posedge i_clk); #1;
        i_reg_write     = 1'b0;
        i_ra_invalidate = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Monitor: every instruction decode accepts must match the queue head
    always @(negedge i_clk) begin
        if (i_reset_n && o_ready && !i_stall) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got instr %h pc %h expected none", o_instruction, o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", o_instruction, e.instr);
                chk("out_pc", o_pc, e.pc);
                chk("out_bp", 32'(o_branch_pred), 32'(e.bp));
            end
        end
    end

    initial begin
        // Reset state
        idle(3);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_instr", o_instruction, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_bp", 32'(o_branch_pred), 32'd0);
        chk("rst_free", 32'(o_free_dword_or_more), 32'd1);
        i_reset_n = 1'b1;
        idle(1);
        i_fetch_pc1 = 1'b1; #1;
        chk("pc_incr_2", o_pc_incr, 32'd2);
        i_fetch_pc1 = 1'b0; #1;
        chk("pc_incr_4", o_pc_incr, 32'd4);
        idle(1);

        // 32-bit addi nop, one cycle latency
        expect_instr(32'h00000013, 32'h0, 1'b0);
        ack(32'h00000013, 32'h0, 1'b0, 32'd0);
        chk("t1_ready", 32'(o_ready), 32'd1);
        idle(2);

        // Two compressed instructions in one word
        expect_instr(32'h00000001, 32'h0, 1'b0);
        expect_instr(32'h00000001, 32'h2, 1'b0);
        ack(32'h00010001, 32'h0, 1'b0, 32'd0);
        idle(3);

        // 32-bit instruction spanning two words
        expect_instr(32'h00000001, 32'h0, 1'b0);
        expect_instr(32'h00000013, 32'h2, 1'b0);
        expect_instr(32'h00000000, 32'h6, 1'b0);
        ack(32'h00130001, 32'h0, 1'b0, 32'd0);
        ack(32'h00000000, 32'h4, 1'b0, 32'd0);
        idle(4);

        // JAL +8 predicted; following sequential word is stale
        expect_instr(32'h0080006F, 32'h100, BP_EN);
        if (!BP_EN) begin
            expect_instr(32'h00000001, 32'h104, 1'b0);
            expect_instr(32'h00000001, 32'h106, 1'b0);
        end
        ack(32'h0080006F, 32'h100, BP_EN, BP_EN ? 32'h108 : 32'd0);
        ack(32'h00010001, 32'h104, 1'b0, 32'd0);
        idle(4);

        // JAL -4 exercises sign extension
        expect_instr(32'hFFDFF06F, 32'h84, BP_EN);
        ack(32'hFFDFF06F, 32'h84, BP_EN, BP_EN ? 32'h80 : 32'd0);
        idle(3);

        // ret through shadow ra, then after invalidate
        reg_wr(5'd1, 32'h200, 1'b0);
        expect_instr(32'h00008067, 32'h10, BP_EN);
        ack(32'h00008067, 32'h10, BP_EN, BP_EN ? 32'h200 : 32'd0);
        idle(2);
        i_ra_invalidate = 1'b1;
        idle(1);
        i_ra_invalidate = 1'b0;
        expect_instr(32'h00008067, 32'h20, 1'b0);
        ack(32'h00008067, 32'h20, 1'b0, 32'd0);
        idle(2);

        // c.jr ra in the high half
        reg_wr(5'd1, 32'h300, 1'b0);
        expect_instr(32'h00008082, 32'h32, BP_EN);
        ack(32'h80820001, 32'h32, BP_EN, BP_EN ? 32'h300 : 32'd0);
        idle(2);

        // Write and invalidate together: invalidate wins
        reg_wr(5'd1, 32'h400, 1'b1);
        expect_instr(32'h00008082, 32'h42, 1'b0);
        ack(32'h80820001, 32'h42, 1'b0, 32'd0);
        idle(2);

        // c.j +8 in low half: trailing halfword dropped when predicted
        expect_instr(32'h0000A021, 32'h60, BP_EN);
        if (!BP_EN) expect_instr(32'h00000001, 32'h62, 1'b0);
        ack(32'h0001A021, 32'h60, BP_EN, BP_EN ? 32'h68 : 32'd0);
        idle(2);

        // c.j -2 in high half
        expect_instr(32'h0000BFFD, 32'h72, BP_EN);
        ack(32'hBFFD0001, 32'h72, BP_EN, BP_EN ? 32'h70 : 32'd0);
        idle(3);

        // Fill under stall, then redirect empties the buffer
        i_stall = 1'b1;
        ack(32'h00000013, 32'h80, 1'b0, 32'd0);
        ack(32'h00000013, 32'h84, 1'b0, 32'd0);
        chk("fill_free_at4", 32'(o_free_dword_or_more), 32'd1);
        ack(32'h00000013, 32'h88, 1'b0, 32'd0);
        chk("fill_free_full", 32'(o_free_dword_or_more), 32'd0);
        chk("fill_ready", 32'(o_ready), 32'd1);
        i_pc_select     = 1'b1;
        i_ack           = 1'b1;
        i_data          = 32'h00000013;
        i_fetch_pc_prev = 32'h8C;
        #1;
        chk("redir_ready_comb", 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        i_pc_select = 1'b0;
        i_ack       = 1'b0;
        chk("redir_ready", 32'(o_ready), 32'd0);
        chk("redir_free", 32'(o_free_dword_or_more), 32'd1);

        // Flush drops pending entries too
        ack(32'h00010001, 32'h200, 1'b0, 32'd0);
        chk("pre_flush_ready", 32'(o_ready), 32'd1);
        i_flush = 1'b1;
        idle(1);
        i_flush = 1'b0;
        chk("flush_ready", 32'(o_ready), 32'd0);
        i_stall = 1'b0;
        idle(2);

        // Normal operation resumes after redirect
        expect_instr(32'h00000013, 32'h300, 1'b0);
        ack(32'h00000013, 32'h300, 1'b0, 32'd0);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_fetch_frontend.md
Name: rv_fetch_frontend

Overview:
Instruction-fetch front end for the RV32 core. It combines a halfword-granular instruction realignment buffer with a static branch predictor. Fetched 32-bit memory words go in; aligned 16/32-bit instructions come out, each with its PC and a predicted-taken flag. It sits between the fetch PC/bus logic and the decode stage.

Parameters:
INSTR_BUF_ADDR_SIZE, 2, log2 of buffer depth in words; the buffer holds 2^(N+1) halfwords.
EXTENSION_C, 1, when 1, compressed C.J/C.JAL/C.JR ra are predicted; when 0, only 32-bit forms are predicted.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_flush  in  1  empty buffer
i_stall  in  1  decode not accepting
i_pc_select  in  1  PC redirect (jump/trap/reset); empty buffer
i_ack  in  1  i_data valid; already aligned to data and gated by redirect
i_data  in  32  fetched word from {i_fetch_pc_prev[31:2],2'b00}
i_fetch_pc1  in  1  bit 1 of the current fetch PC
i_fetch_pc_prev  in  32  PC of the word on i_data
i_ra_invalidate  in  1  clear the shadow-ra valid flag
i_reg_write  in  1  register-file write strobe
i_rd  in  5  write destination
i_reg_wdata  in  32  write data
o_bp_need  out  1  predicted-taken control transfer in the current word (combinational)
o_bp_addr  out  32  predicted target
o_free_dword_or_more  out  1  room to issue another fetch
o_pc_incr  out  32  sequential fetch increment
o_instruction  out  32  head instruction; compressed zero-extended to {16'h0,hw}
o_pc  out  32  PC of head instruction
o_branch_pred  out  1  head instruction was predicted taken
o_ready  out  1  complete instruction available

Behaviour:
- Reset (async):
  - Buffer empty, all entry data/pc/flags 0.
  - o_ready=0, o_instruction=0, o_pc=0, o_branch_pred=0.
  - Shadow ra = 0 and invalid; bp_prev = 0.
- Buffer:
  - Circular FIFO of halfword entries {data16, pc[31:1], bp}, with write/read pointers and a count.
- Write on i_ack, unless i_flush | i_pc_select | bp_prev:
  - If i_fetch_pc_prev[1]=0: push low half (pc = pc_prev), then high half (pc+2).
  - If i_fetch_pc_prev[1]=1: push the high half only.
  - If o_bp_need: tag the jump's first halfword with bp=1 and drop any halfword after the jump in that word.
- bp_prev:
  - Register holding o_bp_need from the previous cycle.
  - The word acked while bp_prev=1 is the stale sequential fetch and is discarded.
- Head decode:
  - head[1:0]!=2'b11 means compressed, needs 1 entry. Otherwise 32-bit, needs 2 entries, o_instruction={hw1,hw0}.
  - o_pc={head.pc,1'b0}. o_branch_pred = head.bp.
- o_ready = enough valid entries & !i_flush & !i_pc_select.
- Pop 1 or 2 entries when o_ready & !i_stall. Push and pop in the same cycle are allowed; count updates by the net amount.
- i_flush or i_pc_select: pointers/count cleared at the next edge; any same-cycle write is dropped.
- o_free_dword_or_more = (free halfwords) >= 4, combinational. This covers one word in flight plus one new request. The buffer never overflows under this rule.
- o_pc_incr = i_fetch_pc1 ? 2 : 4.
- Predictor is combinational on i_data when i_ack & !bp_prev. It examines only the instruction starting at halfword i_fetch_pc_prev[1]:
  - JAL (opcode 1101111, any rd): target = pc_prev + sext J-imm {i[31],i[19:12],i[20],i[30:21],0}.
  - JALR with rs1=x1, imm=0 (ret): target = shadow ra, only if ra valid.
  - EXTENSION_C=1, C.J (funct3 101, op 01) or C.JAL (001, op 01): target = pc_prev + sext CJ-imm.
  - EXTENSION_C=1, C.JR ra (16'h8082): target = shadow ra, only if ra valid.
  - A 32-bit instruction starting at the high half is not predicted.
  - o_bp_addr = target when predicted, else 0.
- Shadow ra:
  - On i_reg_write & i_rd==1: ra <= i_reg_wdata, valid <= 1.
  - i_ra_invalidate sets valid <= 0. Invalidate wins when both occur in the same cycle.

Optional Feature:
FETCH_BRANCH_PRED_EN:
- Defined: predictor and shadow ra are present, as above.
- Undefined: o_bp_need=0, o_bp_addr=0, bp_prev=0, all bp tags 0; i_ra_invalidate, i_reg_write, i_rd and i_reg_wdata are unused. No other behaviour changes.

Test Plan:
- Reset; ack i_data=0x00000013 with pc_prev=0 -> next cycle o_ready=1, o_instruction=0x00000013, o_pc=0, o_branch_pred=0.
- i_data=0x00010001 at pc 0, no stall -> two consecutive outputs of 0x00000001, at o_pc 0 then 2.
- Words 0x00130001 @0 then 0x00000000 @4 -> c.nop at pc 0, then 0x00000013 at pc 2 (spanning instruction).
- i_data=0x0080006F, pc_prev=0x100 -> o_bp_need=1 and o_bp_addr=0x108 in the same cycle; next-cycle ack data is discarded; the jump is output with o_branch_pred=1.
- Write rd=1 with 0x200, then fetch 0x00008067 -> o_bp_addr=0x200. Repeat after i_ra_invalidate -> o_bp_need=0.
- Fill the buffer (o_free_dword_or_more=0), hold i_stall, then pulse i_pc_select -> o_ready=0 next cycle and o_free_dword_or_more=1.
